uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 32 +++
 rtl/uart_rr_arbiter.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its round-robin selector.
package uart_arb_pkg;

   localparam int unsigned MAX_NUM_REQ   = 8;
   localparam int unsigned MAX_IDX_W     = 3;
   localparam int unsigned TMO_W         = 32;
   localparam logic [7:0]  DEF_LOCK_CHAR = 8'h0A;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } arb_state_e;

   // One-entry holding buffer between the owner and the uart_tx instance.
   typedef struct packed {
      logic       full;
      logic [7:0] data;
   } hold_buf_t;

   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_NUM_REQ-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_NUM_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | MAX_IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin selector: first requester at or after (last_grant+1) mod NUM_REQ.
module uart_rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] pick_c,
   output logic               valid_c
);

   always_comb begin
      int unsigned idx;
      logic        found;
      pick_c = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         idx = (32'(last_grant) + off) % NUM_REQ;
         if (!found && req[IDX_W'(idx)]) begin
            pick_c[IDX_W'(idx)] = 1'b1;
            found               = 1'b1;
         end
      end
      valid_c = found;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level arbiter sharing one uart_tx between NUM_REQ byte streams; a grant lasts until LOCK_CHAR.
// Optional idle-owner timeout release is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter logic [7:0]  LOCK_CHAR      = DEF_LOCK_CHAR,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ*8-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_data_valid,
   input  logic                   tx_data_ready,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("uart_tx_arbiter: unsupported parameter set");
   end

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   hold_buf_t          buf_q, buf_d;
   logic               busy_q, busy_d;

   logic [NUM_REQ-1:0] pick_c;
   logic               pick_valid_c;
   logic [7:0]         cap_byte_c;
   logic               owner_valid_c;
   logic               capture_c;
   logic               drain_c;

`ifdef UART_ARB_TIMEOUT_EN
   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
`endif

   uart_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .pick_c     (pick_c),
      .valid_c    (pick_valid_c)
   );

   // Owner's byte and valid, selected by the registered grant index.
   always_comb begin
      cap_byte_c    = '0;
      owner_valid_c = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gidx_q == IDX_W'(i)) begin
            cap_byte_c    = req_data[i*8 +: 8];
            owner_valid_c = req_valid[i];
         end
      end
   end

   assign req_ready = (state_q == XFER && !buf_q.full) ? grant_q : '0;
   assign capture_c = (state_q == XFER) && !buf_q.full && owner_valid_c;
   assign drain_c   = buf_q.full && tx_data_ready;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      gidx_d       = gidx_q;
      last_grant_d = last_grant_q;
      buf_d        = buf_q;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_d    = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_valid_c) begin
               grant_d = pick_c;
               gidx_d  = IDX_W'(onehot_to_idx(MAX_NUM_REQ'(pick_c)));
               state_d = XFER;
            end
         end
         XFER: begin
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q;
`endif
            if (drain_c) begin
               buf_d.full = 1'b0;
            end
            if (capture_c) begin
               buf_d.full = 1'b1;
               buf_d.data = cap_byte_c;
`ifdef UART_ARB_TIMEOUT_EN
               tmo_cnt_d  = '0;
`endif
               if (cap_byte_c == LOCK_CHAR) begin
                  state_d = DRAIN;
               end
            end
`ifdef UART_ARB_TIMEOUT_EN
            // Owner silent with nothing buffered: count toward a forced release.
            else if (!buf_q.full && !owner_valid_c) begin
               if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  last_grant_d = gidx_q;
                  grant_d      = '0;
                  tmo_cnt_d    = '0;
                  state_d      = IDLE;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               end
            end
`endif
         end
         DRAIN: begin
            if (drain_c) begin
               buf_d.full   = 1'b0;
               last_grant_d = gidx_q;
               grant_d      = '0;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         gidx_q       <= '0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         buf_q        <= '0;
         busy_q       <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         tmo_cnt_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         gidx_q       <= gidx_d;
         last_grant_q <= last_grant_d;
         buf_q        <= buf_d;
         busy_q       <= busy_d;
`ifdef UART_ARB_TIMEOUT_EN
         tmo_cnt_q    <= tmo_cnt_d;
`endif
      end
   end

   assign tx_data       = buf_q.data;
   assign tx_data_valid = buf_q.full;
   assign grant         = grant_q;
   assign busy          = busy_q;

endmodule
